operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- Parametrised operand-select pipeline stage between decode/register-read and the ALU.
- For each of NUM_OPS operands, selects none, register, immediate or PC, with register values bypassed from up to NUM_FWD younger in-flight writers.
- Detects load-use hazards and stalls the upstream stage.
- Registers the selected operands behind a valid/ready handshake and counts stall cycles.

Parameters:
- XLEN, 32, operand/data width.
- NUM_OPS, 2, number of operand channels.
- NUM_FWD, 2, number of forwarding sources; index 0 is youngest and has highest priority.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage accepts input this cycle
- rs  in  NUM_OPS*5  source register index per operand
- regdata  in  NUM_OPS*XLEN  register-file read data per operand
- imm  in  XLEN  immediate, shared by all operands
- pc  in  XLEN  instruction PC, shared
- op_type  in  NUM_OPS*2  OP_TYPE_* code per operand
- fwd_we  in  NUM_FWD  source writes a register
- fwd_pend  in  NUM_FWD  source result not yet available (load in flight)
- fwd_rd  in  NUM_FWD*5  destination index per source
- fwd_data  in  NUM_FWD*XLEN  result per source
- flush  in  1  synchronous kill of the held and incoming instruction
- out_valid  out  1  registered operands valid
- out_ready  in  1  ALU accepts
- op  out  NUM_OPS*XLEN  selected operands; operand k is at [k*XLEN +: XLEN]
- stall_cnt  out  CNT_W  hazard stall cycles

Behaviour:
- Reset (async, rst_n=0): out_valid=0, op=0, stall_cnt=0. in_ready is combinational and goes low while out_valid=0 only if a hazard is present.
- Per-operand select:
  - OP_TYPE_NONE gives 0.
  - OP_TYPE_IMM gives imm.
  - OP_TYPE_PC gives pc.
  - OP_TYPE_REG gives the forwarded or register value.
  - Any undefined code gives 0.
- Forward match for source j: fwd_we[j] && fwd_rd[j]!=0 && fwd_rd[j]==rs[k]. The lowest matching j wins; with no match the operand takes regdata[k].
- rs[k]==0 never matches and never forwards; the operand passes regdata.
- Hazard: in_valid && some operand has type REG && its winning match has fwd_pend=1.
  - A pending source hidden behind a higher-priority non-pending match does not stall.
  - Operands of type other than REG never stall.
- in_ready = (!out_valid || out_ready) && !hazard.
- Capture on in_valid && in_ready && !flush: op registers load, and out_valid=1 next cycle. Latency is 1 cycle; throughput is 1 per cycle.
- Output holds stable while out_valid && !out_ready.
- out_valid clears on a cycle with out_ready and no capture.
- flush has priority over capture and hold: out_valid=0 next cycle, no capture, op value unchanged (don't-care).
- stall_cnt increments on each cycle where hazard=1, regardless of flush, and saturates at 2^CNT_W-1.
- Reset mid-transfer: the held instruction is dropped.

Decomposition:
- OP_TYPE_* codes stay in define.vh.
- Add OPSTG_FWD_PRIO_YOUNGEST documentation macro if needed; no other shared constants.
- Sub-module operand_mux (combinational): one operand's forward priority search, pending flag and type select; instantiated NUM_OPS times via generate.
- The top level holds the handshake, pipeline register and counter.

Test Plan:
- After reset, drive in_valid=1, types {REG,IMM}, regdata0=0x11, imm=0x22, out_ready=1 → next cycle out_valid=1, op0=0x11, op1=0x22, stall_cnt=0.
- Forward priority: rs0=5, fwd_rd={5,5}, fwd_we=2'b11, fwd_data0=0xA, fwd_data1=0xB → op0=0xA. With fwd_we0=0 → op0=0xB. With rs0=0 → op0=regdata0.
- Load-use: rs1=7, fwd_rd0=7, fwd_pend0=1 for 3 cycles → in_ready=0 for 3 cycles, stall_cnt=3. On the pend drop, capture of fwd_data0.
- Backpressure: out_ready=0 for 4 cycles with continuous in_valid → in_ready=0, op stable. Release → one transfer per cycle.
- PC/NONE: types {PC,NONE}, pc=0x80000004 → op0=0x80000004, op1=0. An undefined code is not applicable with 2 bits; check each type on each channel.
- Flush with in_valid=1 and out_valid=1 → out_valid=0 next cycle. Async rst_n low mid-stall → out_valid=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// Shared operand-type encoding and register-index width for the operand stage.
package operand_stage_pkg;

  typedef enum logic [1:0] {
    OP_TYPE_NONE = 2'd0,
    OP_TYPE_REG  = 2'd1,
    OP_TYPE_IMM  = 2'd2,
    OP_TYPE_PC   = 2'd3
  } op_type_e;

  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/operand_stage_mux.sv
// One operand channel: forwarding priority search, pending flag and type select.
module operand_mux
  import operand_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_IDX_W-1:0]         rs,
  input  logic [XLEN-1:0]              regdata,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              pc,
  input  logic [1:0]                   op_type,
  input  logic [NUM_FWD-1:0]           fwd_we,
  input  logic [NUM_FWD-1:0]           fwd_pend,
  input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data,
  output logic [XLEN-1:0]              operand,
  output logic                         pend
);

  logic [XLEN-1:0] reg_val;
  logic            reg_pend;

  always_comb begin
    reg_val  = regdata;
    reg_pend = 1'b0;
    // Scan oldest to youngest so the youngest (lowest index) match is the last write.
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_we[j] && (rs != '0) && (fwd_rd[j*REG_IDX_W +: REG_IDX_W] == rs)) begin
        reg_val  = fwd_data[j*XLEN +: XLEN];
        reg_pend = fwd_pend[j];
      end
    end

    operand = '0;
    pend    = 1'b0;
    case (op_type_e'(op_type))
      OP_TYPE_REG: begin
        operand = reg_val;
        pend    = reg_pend;
      end
      OP_TYPE_IMM: operand = imm;
      OP_TYPE_PC:  operand = pc;
      default:     operand = '0;
    endcase
  end

endmodule

// File: rtl/operand_stage.sv
// Operand-select pipeline stage: per-operand bypass muxes, load-use stall,
// valid/ready output register and saturating stall counter.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_OPS = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_OPS*REG_IDX_W-1:0] rs,
  input  logic [NUM_OPS*XLEN-1:0]      regdata,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              pc,
  input  logic [NUM_OPS*2-1:0]         op_type,
  input  logic [NUM_FWD-1:0]           fwd_we,
  input  logic [NUM_FWD-1:0]           fwd_pend,
  input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_OPS*XLEN-1:0]      op,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic [NUM_OPS*XLEN-1:0] sel_ops;
  logic [NUM_OPS-1:0]      op_pend;
  logic                    hazard;
  logic                    capture;

  logic                    out_valid_q, out_valid_d;
  logic [NUM_OPS*XLEN-1:0] op_q, op_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    operand_mux #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD)
    ) u_mux (
      .rs       (rs[k*REG_IDX_W +: REG_IDX_W]),
      .regdata  (regdata[k*XLEN +: XLEN]),
      .imm      (imm),
      .pc       (pc),
      .op_type  (op_type[k*2 +: 2]),
      .fwd_we   (fwd_we),
      .fwd_pend (fwd_pend),
      .fwd_rd   (fwd_rd),
      .fwd_data (fwd_data),
      .operand  (sel_ops[k*XLEN +: XLEN]),
      .pend     (op_pend[k])
    );
  end

  assign hazard   = in_valid && (|op_pend);
  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      op_d        = sel_ops;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Stalls are counted even on flush cycles.
    stall_cnt_d = hazard ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: spec-level model predicts readiness,
// captured operands, output valid and the saturating stall counter.
module tb_operand_stage;
  import operand_stage_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_OPS = 2;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_OPS*5-1:0]    rs;
  logic [NUM_OPS*XLEN-1:0] regdata;
  logic [XLEN-1:0]         imm;
  logic [XLEN-1:0]         pc;
  logic [NUM_OPS*2-1:0]    op_type;
  logic [NUM_FWD-1:0]      fwd_we;
  logic [NUM_FWD-1:0]      fwd_pend;
  logic [NUM_FWD*5-1:0]    fwd_rd;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_OPS*XLEN-1:0] op;
  logic [CNT_W-1:0]        stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [NUM_OPS*XLEN-1:0] sb_q[$];
  logic                    exp_vld;
  logic [CNT_W-1:0]        exp_cnt;

  operand_stage #(
    .XLEN(XLEN), .NUM_OPS(NUM_OPS), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .regdata(regdata), .imm(imm), .pc(pc), .op_type(op_type),
    .fwd_we(fwd_we), .fwd_pend(fwd_pend), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op(op),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_OPS*XLEN-1:0] model_ops(output logic haz);
    logic [NUM_OPS*XLEN-1:0] r;
    haz = 1'b0;
    r   = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      logic [4:0]      s;
      logic [XLEN-1:0] v;
      logic            p;
      s = rs[k*5 +: 5];
      v = regdata[k*XLEN +: XLEN];
      p = 1'b0;
      if (s != 5'd0) begin
        for (int j = 0; j < NUM_FWD; j++) begin
          if (fwd_we[j] && fwd_rd[j*5 +: 5] == s) begin
            v = fwd_data[j*XLEN +: XLEN];
            p = fwd_pend[j];
            break;
          end
        end
      end
      case (op_type[k*2 +: 2])
        2'd1: begin r[k*XLEN +: XLEN] = v; haz = haz | (in_valid & p); end
        2'd2: r[k*XLEN +: XLEN] = imm;
        2'd3: r[k*XLEN +: XLEN] = pc;
        default: r[k*XLEN +: XLEN] = '0;
      endcase
    end
    return r;
  endfunction

  task automatic step();
    logic [NUM_OPS*XLEN-1:0] e;
    logic h, rdy, cap;
    @(negedge clk);
    e   = model_ops(h);
    rdy = (!exp_vld || out_ready) && !h;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, exp_vld);
    chk("stall_cnt", stall_cnt, exp_cnt);
    if (exp_vld) begin
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("op", op, sb_q[0]);
      if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
    end
    cap = in_valid && rdy && !flush;
    if (flush) begin
      sb_q.delete();
      exp_vld = 1'b0;
    end else if (cap) begin
      sb_q.push_back(e);
      exp_vld = 1'b1;
    end else if (out_ready) begin
      exp_vld = 1'b0;
    end
    if (h && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ty(input int k, input logic [1:0] t); op_type[k*2 +: 2] = t; endtask
  task automatic set_rs(input int k, input logic [4:0] v); rs[k*5 +: 5] = v; endtask
  task automatic set_rd(input int j, input logic [4:0] v); fwd_rd[j*5 +: 5] = v; endtask
  task automatic set_fd(input int j, input logic [XLEN-1:0] v); fwd_data[j*XLEN +: XLEN] = v; endtask
  task automatic set_rg(input int k, input logic [XLEN-1:0] v); regdata[k*XLEN +: XLEN] = v; endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs = '0; regdata = '0; imm = '0; pc = '0;
    op_type = '0; fwd_we = '0; fwd_pend = '0; fwd_rd = '0; fwd_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    exp_vld = 1'b0; exp_cnt = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op", op, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic REG/IMM select
    in_valid = 1'b1; set_ty(0, OP_TYPE_REG); set_ty(1, OP_TYPE_IMM);
    set_rs(0, 5'd3); set_rg(0, 32'h11); imm = 32'h22;
    step();
    chk("t1_op", op, {32'h22, 32'h11});
    chk("t1_vld", out_valid, 1);

    // Forward priority
    set_rs(0, 5'd5); set_rd(0, 5'd5); set_rd(1, 5'd5); fwd_we = 2'b11;
    set_fd(0, 32'hA); set_fd(1, 32'hB);
    step(); chk("fwd_young", op[31:0], 32'hA);
    fwd_we = 2'b10;
    step(); chk("fwd_old", op[31:0], 32'hB);
    fwd_we = 2'b11; set_rs(0, 5'd0); set_rd(0, 5'd0); set_rd(1, 5'd0);
    step(); chk("fwd_x0", op[31:0], 32'h11);

    // Load-use stall on operand 1, then capture of the forwarded result
    set_ty(0, OP_TYPE_IMM); set_ty(1, OP_TYPE_REG); set_rs(1, 5'd7);
    set_rd(0, 5'd7); set_rd(1, 5'd9); fwd_we = 2'b11; fwd_pend = 2'b01; set_fd(0, 32'hCAFE);
    repeat (3) step();
    chk("lu_cnt3", stall_cnt, 3);
    fwd_pend = 2'b00;
    step();
    chk("lu_capture", op[63:32], 32'hCAFE);
    // Pending older source hidden behind non-pending younger match
    set_rd(1, 5'd7); fwd_pend = 2'b10;
    step();
    chk("hidden_pend_cnt", stall_cnt, 3);

    // Saturation of the stall counter
    fwd_pend = 2'b01;
    repeat (20) step();
    chk("cnt_sat", stall_cnt, 15);
    fwd_pend = 2'b00;

    // Backpressure then release
    set_ty(0, OP_TYPE_REG); set_rs(0, 5'd2); set_ty(1, OP_TYPE_IMM);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin set_rg(0, 32'h100 + i); imm = 32'h200 + i; step(); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin set_rg(0, 32'h300 + i); step(); end

    // Every type on every channel
    pc = 32'h8000_0004; set_rs(1, 5'd4);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        set_ty(0, 2'(a)); set_ty(1, 2'(b));
        set_rg(0, $urandom); set_rg(1, $urandom); imm = $urandom;
        step();
      end
    set_ty(0, OP_TYPE_PC); set_ty(1, OP_TYPE_NONE);
    step();
    chk("pc_none", op, {32'h0, 32'h8000_0004});

    // Flush while holding and while transferring
    out_ready = 1'b0; set_ty(0, OP_TYPE_IMM); step();
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; step();
    chk("flush_hold", out_valid, 0);
    in_valid = 1'b1; out_ready = 1'b1; step();
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; step();
    chk("flush_xfer", out_valid, 0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NUM_OPS; k++) begin
        set_ty(k, 2'($urandom_range(0, 3))); set_rs(k, 5'($urandom_range(0, 3)));
        set_rg(k, $urandom);
      end
      for (int j = 0; j < NUM_FWD; j++) begin
        set_rd(j, 5'($urandom_range(0, 3))); set_fd(j, $urandom);
      end
      fwd_we = 2'($urandom); fwd_pend = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      imm = $urandom; pc = $urandom;
      step();
    end

    // Async reset in the middle of a stall with a held output
    flush = 1'b0; fwd_pend = 2'b00; fwd_we = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    set_ty(0, OP_TYPE_IMM); set_ty(1, OP_TYPE_IMM);
    step(); step();
    set_ty(1, OP_TYPE_REG); set_rs(1, 5'd6); set_rd(0, 5'd6); fwd_we = 2'b01; fwd_pend = 2'b01;
    step(); step();
    chk("pre_rst_vld", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", out_valid, 0);
    chk("async_rst_cnt", stall_cnt, 0);
    sb_q.delete(); exp_vld = 1'b0; exp_cnt = '0;
    in_valid = 1'b0; fwd_pend = 2'b00; out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; set_ty(0, OP_TYPE_PC);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
